// File: rtl/dmem_xfer_pkg.sv
// Shared types and default widths for the data-memory port controller.
package dmem_xfer_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_LW = DEF_AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_xfer.sv
// Data-memory port controller: muxes the single memory port between the CPU
// load/store path and a byte-at-a-time block-copy engine.
module dmem_xfer
    import dmem_xfer_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_stall,
    input  logic          xfer_start,
    input  logic [AW-1:0] xfer_src,
    input  logic [AW-1:0] xfer_dst,
    input  logic [LW-1:0] xfer_len,
    output logic          xfer_busy,
    output logic          xfer_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output state_t        dbgState
);

    // Handshake: a CPU request (cpu_rd/cpu_wr) is accepted in any cycle where
    // cpu_stall=0; while stalled the CPU holds its request unchanged.
    // xfer_start is a single-cycle strobe honoured only in IDLE.

    state_t        state;
    logic [AW-1:0] srcPtr;
    logic [AW-1:0] dstPtr;
    logic [LW-1:0] cnt;
    logic [7:0]    dataBuf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            srcPtr    <= '0;
            dstPtr    <= '0;
            cnt       <= '0;
            dataBuf   <= '0;
            xfer_busy <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer_start) begin
                        srcPtr <= xfer_src;
                        dstPtr <= xfer_dst;
                        cnt    <= xfer_len;
                        if (xfer_len != '0) begin
                            state     <= RD;
                            xfer_busy <= 1'b1;
                        end else begin
                            state     <= DONE;
                            xfer_done <= 1'b1;
                        end
                    end
                end
                RD: begin
                    dataBuf <= mem_rdata;
                    srcPtr  <= srcPtr + AW'(1);
                    state   <= WR;
                end
                WR: begin
                    dstPtr <= dstPtr + AW'(1);
                    cnt    <= cnt - LW'(1);
                    if (cnt != LW'(1)) begin
                        state <= RD;
                    end else begin
                        state     <= DONE;
                        xfer_busy <= 1'b0;
                        xfer_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_read  = cpu_rd;
        mem_write = cpu_wr;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        case (state)
            RD: begin
                mem_addr  = srcPtr;
                mem_read  = 1'b1;
                mem_write = 1'b0;
                cpu_stall = cpu_rd | cpu_wr;
            end
            WR: begin
                mem_addr  = dstPtr;
                mem_read  = 1'b0;
                mem_write = 1'b1;
                mem_wdata = dataBuf;
                cpu_stall = cpu_rd | cpu_wr;
            end
            DONE: begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
                cpu_stall = cpu_rd | cpu_wr;
            end
            default: ;
        endcase
        // A reset cycle must never commit a write, even mid-copy.
        if (!rst_n) begin
            mem_write = 1'b0;
            cpu_stall = 1'b0;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dbgState  = state;

endmodule

// File: tb/tb_dmem_xfer.sv
// Randomized bench for dmem_xfer: a bench-side memory, a sequential reference
// copy model and an expected-write queue drive all expectations.
module tb_dmem_xfer;
    import dmem_xfer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic        xfer_start;
    logic [7:0]  xfer_src;
    logic [7:0]  xfer_dst;
    logic [8:0]  xfer_len;
    logic        xfer_busy;
    logic        xfer_done;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    state_t      dbgState;

    logic [7:0]  mem [256];
    logic [7:0]  refMem [256];
    logic [15:0] exp_q [$];
    int          vecCnt = 0;
    int          errCnt = 0;

    dmem_xfer #(.AW(8), .LW(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .xfer_start(xfer_start), .xfer_src(xfer_src), .xfer_dst(xfer_dst),
        .xfer_len(xfer_len), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbgState(dbgState)
    );

    // Memory: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cpuWrite(input logic [7:0] addr, input logic [7:0] data);
        cpu_addr = addr; cpu_wdata = data; cpu_wr = 1'b1;
        #1;
        checkVal("wr_stall", {31'b0, cpu_stall}, 0);
        checkVal("wr_pulse", {31'b0, mem_write}, 1);
        refMem[addr] = data;
        tick();
        cpu_wr = 1'b0;
        #1;
        checkVal("wr_release", {31'b0, mem_write}, 0);
    endtask

    task automatic cpuRead(input logic [7:0] addr);
        cpu_addr = addr; cpu_rd = 1'b1;
        #1;
        checkVal("rd_stall", {31'b0, cpu_stall}, 0);
        checkVal("rd_enable", {31'b0, mem_read}, 1);
        checkVal("rd_data", {24'b0, cpu_rdata}, {24'b0, refMem[addr]});
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic checkMem();
        for (int a = 0; a < 256; a++) begin
            vecCnt++;
            if (mem[a] !== refMem[a]) begin
                errCnt++;
                $display("FAIL mem[%0h]: got 0x%0h expected 0x%0h", a, mem[a], refMem[a]);
            end
        end
    endtask

    // mode 0: plain copy; 1: stalled CPU load plus ignored second start;
    // 2: reset asserted in the second WR cycle (cycle 4).
    task automatic runCopy(input int src, input int dst, input int len, input int mode);
        int       cycles;
        int       nBytes;
        int       rdAddr;
        logic [7:0] v;
        logic [15:0] e;
        rdAddr = $urandom_range(0, 255);
        nBytes = (mode == 2) ? 1 : len;
        // Reference: ascending byte-by-byte copy with 8-bit wrap.
        exp_q.delete();
        for (int k = 0; k < nBytes; k++) begin
            v = refMem[(src + k) & 255];
            exp_q.push_back({8'((dst + k) & 255), v});
            refMem[(dst + k) & 255] = v;
        end
        xfer_src = 8'(src); xfer_dst = 8'(dst); xfer_len = 9'(len);
        xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
        cycles = (len == 0) ? 1 : 2 * len + 1;
        for (int c = 1; c <= cycles; c++) begin
            if (mode == 1 && c == 1) begin cpu_rd = 1'b1; cpu_addr = 8'(rdAddr); end
            if (mode == 1 && c == 3) begin
                xfer_start = 1'b1; xfer_src = 8'($urandom); xfer_dst = 8'($urandom); xfer_len = 9'd5;
            end
            if (mode == 1 && c == 4) xfer_start = 1'b0;
            if (mode == 2 && c == 4) begin
                rst_n = 1'b0;
                #1;
                checkVal("rst_no_write", {31'b0, mem_write}, 0);
                tick();
                rst_n = 1'b1;
                #1;
                checkVal("rst_state", {30'b0, dbgState}, {30'b0, IDLE});
                checkVal("rst_busy", {31'b0, xfer_busy}, 0);
                checkVal("rst_done", {31'b0, xfer_done}, 0);
                tick();
                checkVal("rst_no_done_later", {31'b0, xfer_done}, 0);
                checkVal("rst_queue_empty", exp_q.size(), 0);
                return;
            end
            #1;
            checkVal("busy", {31'b0, xfer_busy}, (c <= 2 * len) ? 1 : 0);
            checkVal("done", {31'b0, xfer_done}, (c == cycles) ? 1 : 0);
            checkVal("write", {31'b0, mem_write}, (c <= 2 * len && c % 2 == 0) ? 1 : 0);
            if (mode == 1) checkVal("stall", {31'b0, cpu_stall}, 1);
            if (mem_write) begin
                if (exp_q.size() == 0) begin
                    checkVal("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkVal("write_word", {16'b0, mem_addr, mem_wdata}, {16'b0, e});
                end
            end
            tick();
        end
        #1;
        checkVal("idle_busy", {31'b0, xfer_busy}, 0);
        checkVal("idle_done", {31'b0, xfer_done}, 0);
        checkVal("idle_stall", {31'b0, cpu_stall}, 0);
        checkVal("all_writes_seen", exp_q.size(), 0);
        if (mode == 1) begin
            checkVal("stalled_load", {24'b0, cpu_rdata}, {24'b0, refMem[rdAddr]});
            cpu_rd = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                checkVal("second_start_ignored", {31'b0, xfer_busy}, 0);
            end
        end
        tick();
    endtask

    initial begin
        int s, d, l;
        rst_n = 1'b0; cpu_addr = '0; cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_wdata = '0;
        xfer_start = 1'b0; xfer_src = '0; xfer_dst = '0; xfer_len = '0;
        tick();
        tick();
        checkVal("reset_state", {30'b0, dbgState}, {30'b0, IDLE});
        checkVal("reset_busy", {31'b0, xfer_busy}, 0);
        checkVal("reset_done", {31'b0, xfer_done}, 0);
        checkVal("reset_stall", {31'b0, cpu_stall}, 0);
        checkVal("reset_write_mask", {31'b0, mem_write}, 0);
        cpu_wr = 1'b0;
        rst_n = 1'b1;
        tick();

        for (int a = 0; a < 256; a++) cpuWrite(8'(a), 8'($urandom));
        checkMem();

        cpuWrite(8'h10, 8'h5A);
        cpuRead(8'h10);

        cpuWrite(8'h20, 8'h11); cpuWrite(8'h21, 8'h22);
        cpuWrite(8'h22, 8'h33); cpuWrite(8'h23, 8'h44);
        runCopy(8'h20, 8'h80, 4, 0);
        checkMem();

        cpuWrite(8'hFE, 8'hA1); cpuWrite(8'hFF, 8'hA2); cpuWrite(8'h00, 8'hA3);
        runCopy(8'hFE, 8'h01, 3, 0);
        checkMem();

        runCopy(8'h40, 8'h50, 0, 0);
        runCopy(8'h30, 8'h60, 3, 1);
        checkMem();
        runCopy(8'h90, 8'hC0, 4, 2);
        checkMem();

        runCopy(8'h05, 8'h07, 10, 0);
        checkMem();
        runCopy(8'h33, 8'hB7, 256, 0);
        checkMem();
        for (int t = 0; t < 8; t++) begin
            s = $urandom_range(0, 255);
            d = $urandom_range(0, 255);
            l = $urandom_range(0, 40);
            runCopy(s, d, l, 0);
            if ($urandom_range(0, 1) == 1) cpuRead(8'($urandom));
            checkMem();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
